agc_div_scheduler: RTL and testbench

Round-robin scheduler that shares one instance of the AGC divider datapath (reference/error in, quotient/remainder/valid out) between up to N_CH gain channels. It arbitrates channel requests, latches the winning channel's operands, launches the divider with a one-cycle start, waits for the result with a timeout guard, and returns the registered result to the requesting channel with a one-cycle done pulse. It sits between the per-channel AGC loop logic and the single shared divider.

---
 rtl/agc_div_scheduler.sv | 152 +++++++++++++++
 tb/tb_agc_div_scheduler.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_div_scheduler.sv
// agc_div_scheduler: round-robin share of one AGC divider
// across N_CH channels, with stale-valid guard and timeout.
module agc_div_scheduler #(
  parameter int DATA_SIZE      = 14,
  parameter int REMAINDER_SIZE = 8,
  parameter int N_CH           = 4,
  parameter int TIMEOUT        = 63
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [N_CH-1:0]             i_req,
  input  logic [N_CH*DATA_SIZE-1:0]   i_reference,
  input  logic [N_CH*DATA_SIZE-1:0]   i_error,
  output logic [DATA_SIZE-1:0]        o_div_reference,
  output logic [DATA_SIZE-1:0]        o_div_error,
  output logic                        o_div_start,
  input  logic [DATA_SIZE-1:0]        i_div_quotient,
  input  logic [REMAINDER_SIZE-1:0]   i_div_remainder,
  input  logic                        i_div_valid,
  output logic [DATA_SIZE-1:0]        o_quotient,
  output logic [REMAINDER_SIZE-1:0]   o_remainder,
  output logic [N_CH-1:0]             o_done,
  output logic                        o_timeout,
  output logic                        o_busy,
  output logic [2:0]                  o_ch_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]                r_rr;
  logic [2:0]                r_ch_id;
  logic [7:0]                r_cnt;
  logic                      r_seen_low;
  logic [DATA_SIZE-1:0]      r_ref;
  logic [DATA_SIZE-1:0]      r_err;
  logic [DATA_SIZE-1:0]      r_q;
  logic [REMAINDER_SIZE-1:0] r_r;
  logic                      r_to;

  logic       w_any;
  logic [2:0] w_grant;
  logic       w_accept;
  logic       w_expire;

  // Rotating priority: lowest offset from r_rr wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (i_req[(int'(r_rr) + k) % N_CH]) begin
        w_any   = 1'b1;
        w_grant = 3'((int'(r_rr) + k) % N_CH);
      end
    end
  end

  // A valid level left over from the previous op is ignored.
  assign w_accept = i_div_valid && r_seen_low;
  assign w_expire = (r_cnt == 8'(TIMEOUT));

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (w_accept || w_expire) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand latch, wait bookkeeping, result capture, pointer.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rr       <= '0;
      r_ch_id    <= '0;
      r_cnt      <= '0;
      r_seen_low <= 1'b0;
      r_ref      <= '0;
      r_err      <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_to       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ch_id <= w_grant;
            r_ref   <= i_reference[int'(w_grant)*DATA_SIZE +: DATA_SIZE];
            r_err   <= i_error[int'(w_grant)*DATA_SIZE +: DATA_SIZE];
          end
        end
        S_LAUNCH: begin
          r_cnt      <= '0;
          r_seen_low <= 1'b0;
        end
        S_WAIT: begin
          if (!i_div_valid) r_seen_low <= 1'b1;
          if (w_accept) begin
            r_q  <= i_div_quotient;
            r_r  <= i_div_remainder;
            r_to <= 1'b0;
          end else if (w_expire) begin
            r_q  <= '0;
            r_r  <= '0;
            r_to <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (r_ch_id == 3'(N_CH - 1)) r_rr <= '0;
          else                         r_rr <= r_ch_id + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // One-hot done pulse to the served channel.
  always_comb begin
    o_done = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_state == S_DONE && r_ch_id == 3'(k)) o_done[k] = 1'b1;
    end
  end

  assign o_div_start     = (r_state == S_LAUNCH);
  assign o_busy          = (r_state != S_IDLE);
  assign o_div_reference = r_ref;
  assign o_div_error     = r_err;
  assign o_quotient      = r_q;
  assign o_remainder     = r_r;
  assign o_timeout       = r_to;
  assign o_ch_id         = r_ch_id;

endmodule

// File: tb/tb_agc_div_scheduler.sv
// tb_agc_div_scheduler: scoreboard bench with a behavioural
// divider and a round-robin service-order reference model.
module tb_agc_div_scheduler;

  localparam int DW = 14;
  localparam int RW = 8;
  localparam int N  = 4;
  localparam int T  = 63;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] refv;
  logic [N*DW-1:0] errv;
  logic [DW-1:0]   dq;
  logic [RW-1:0]   dr;
  logic            dvalid;
  logic [DW-1:0]   div_ref;
  logic [DW-1:0]   div_err;
  logic            start;
  logic [DW-1:0]   q_o;
  logic [RW-1:0]   r_o;
  logic [N-1:0]    done;
  logic            to_o;
  logic            busy;
  logic [2:0]      chid;

  always #5 clk = ~clk;

  agc_div_scheduler #(
    .DATA_SIZE(DW), .REMAINDER_SIZE(RW), .N_CH(N), .TIMEOUT(T)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_req(req),
    .i_reference(refv),
    .i_error(errv),
    .o_div_reference(div_ref),
    .o_div_error(div_err),
    .o_div_start(start),
    .i_div_quotient(dq),
    .i_div_remainder(dr),
    .i_div_valid(dvalid),
    .o_quotient(q_o),
    .o_remainder(r_o),
    .o_done(done),
    .o_timeout(to_o),
    .o_busy(busy),
    .o_ch_id(chid)
  );

  typedef struct {
    logic [N-1:0]  done;
    logic [DW-1:0] q;
    logic [RW-1:0] r;
    logic          to;
    int            lat;
    int            t0;
  } exp_t;

  exp_t sb[$];
  int   served[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   nstart = 0;
  int   ndone  = 0;

  logic [DW-1:0] ref_m[N];
  logic [DW-1:0] err_m[N];
  logic [N-1:0]  smask;
  int            rr_m = 0;
  bit            inserv[N];
  bit            keep[N];
  bit            dropq[N];

  int            fix_to = 0;
  int            fix_h  = 0;
  int            fix_l  = 1;
  int            p_to   = 10;
  int            p_stale = 15;
  int            p_drop = 0;
  bit            ovr = 1'b0;
  logic [DW-1:0] ovr_q;
  logic [RW-1:0] ovr_r;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    smask <= req;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  busy,    0);
    chk({tag, "_start"}, start,   0);
    chk({tag, "_done"},  done,    0);
    chk({tag, "_to"},    to_o,    0);
    chk({tag, "_chid"},  chid,    0);
    chk({tag, "_q"},     q_o,     0);
    chk({tag, "_r"},     r_o,     0);
    chk({tag, "_dref"},  div_ref, 0);
    chk({tag, "_derr"},  div_err, 0);
  endtask

  task automatic raise(input int k, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    ref_m[k] = a;
    err_m[k] = b;
    refv[k*DW +: DW] = a;
    errv[k*DW +: DW] = b;
    req[k] = 1'b1;
  endtask

  task automatic wait_done(input int n, input int budget);
    int tgt;
    tgt = ndone + n;
    for (int i = 0; i < budget && ndone < tgt; i++) @(posedge clk);
    #1;
    chk("wait_done", (ndone >= tgt), 1);
  endtask

  task automatic chk_order(input string nm, input int a, input int b,
                           input int c, input int n);
    int want[3];
    want[0] = a;
    want[1] = b;
    want[2] = c;
    chk({nm, "_count"}, served.size(), n);
    for (int i = 0; i < n && i < served.size(); i++)
      chk({nm, "_order"}, served[i], (i < 3) ? want[i] : i);
  endtask

  // Divider: predicts the grant, checks operands, queues the
  // expected result and plays back a valid waveform.
  initial begin : divider
    dvalid = 1'b0;
    dq = '0;
    dr = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && start === 1'b1) begin
        int   ch;
        int   h;
        int   l;
        bit   tmo;
        exp_t e;
        nstart++;
        ch = -1;
        for (int k = N - 1; k >= 0; k--)
          if (smask[(rr_m + k) % N]) ch = (rr_m + k) % N;
        chk("grant_exists", (ch >= 0), 1);
        if (ch < 0) ch = 0;
        chk("start_ch", chid, ch);
        chk("start_ref", div_ref, ref_m[ch]);
        chk("start_err", div_err, err_m[ch]);
        chk("start_busy", busy, 1);
        rr_m = (ch + 1) % N;
        inserv[ch] = 1'b1;
        tmo = (fix_to >= 0) ? (fix_to != 0)
                            : ($urandom_range(0, 99) < p_to);
        h = (fix_h >= 0) ? fix_h
          : (($urandom_range(0, 99) < p_stale) ? $urandom_range(1, 4) : 0);
        l = (fix_l >= 0) ? fix_l : $urandom_range(1, 12);
        e.done = '0;
        e.done[ch] = 1'b1;
        e.t0 = cyc;
        if (tmo) begin
          e.q = '0;
          e.r = '0;
          e.to = 1'b1;
          e.lat = T + 2;
        end else begin
          if (ovr) begin
            e.q = ovr_q;
            e.r = ovr_r;
          end else if (err_m[ch] == '0) begin
            e.q = '1;
            e.r = ref_m[ch][RW-1:0];
          end else begin
            e.q = ref_m[ch] / err_m[ch];
            e.r = RW'(ref_m[ch] % err_m[ch]);
          end
          e.to = 1'b0;
          e.lat = h + l + 2;
        end
        sb.push_back(e);
        if (!keep[ch] && $urandom_range(0, 99) < p_drop) req[ch] = 1'b0;
        if (tmo) begin
          dq = 14'h2aaa;
          dr = 8'h5a;
        end else begin
          dq = e.q;
          dr = e.r;
          if (h > 0) dvalid = 1'b1;
          for (int j = 0; j <= h + l; j++) begin
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) break;
            dvalid = (j < h) || (j == h + l);
          end
          @(posedge clk);
          #1;
          dvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: pops and compares on every done pulse.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done !== '0) begin
        exp_t e;
        int   idx;
        idx = -1;
        for (int k = 0; k < N; k++) if (done[k]) idx = k;
        served.push_back(idx);
        ndone++;
        if (sb.size() == 0) begin
          chk("sb_nonempty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("done_onehot", done, e.done);
          chk("done_q", q_o, e.q);
          chk("done_r", r_o, e.r);
          chk("done_to", to_o, e.to);
          chk("done_lat", cyc - e.t0, e.lat);
          chk("done_busy", busy, 1);
        end
      end
    end
  end

  // Requester side: release or keep the line after service.
  initial begin : release_p
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1)
        for (int k = 0; k < N; k++)
          if (done[k] === 1'b1) begin
            inserv[k] = 1'b0;
            if (!keep[k]) dropq[k] = 1'b1;
          end
    end
  end

  initial begin : driver
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if (dropq[k]) begin
          req[k] = 1'b0;
          dropq[k] = 1'b0;
        end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no_finish want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 1'b1;
    req = '0;
    refv = '0;
    errv = '0;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request on ch1, result 20 cycles after start.
    begin
      int s0;
      s0 = nstart;
      fix_to = 0; fix_h = 0; fix_l = 19;
      ovr = 1'b1; ovr_q = 14'h0002; ovr_r = 8'h58;
      served.delete();
      raise(1, 14'h1030, 14'h2FF8);
      wait_done(1, 200);
      ovr = 1'b0;
      chk("t1_starts", nstart - s0, 1);
      chk_order("t1", 1, 0, 0, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("t1_hold_q", q_o, 14'h0002);
      chk("t1_hold_r", r_o, 8'h58);
      chk("t1_idle", busy, 0);
    end

    // All four at once straight out of reset.
    @(posedge clk);
    #1 rst_n = 1'b0;
    rr_m = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    fix_l = -1;
    served.delete();
    for (int k = 0; k < N; k++)
      raise(k, 14'($urandom), 14'($urandom_range(1, 16383)));
    wait_done(4, 400);
    chk_order("t2", 0, 1, 2, 4);
    if (served.size() == 4) chk("t2_last", served[3], 3);
    repeat (3) @(posedge clk);
    #1;

    // Ch2 held high; ch0 joins after ch2's first service.
    served.delete();
    keep[2] = 1'b1;
    raise(2, 14'h0123, 14'h0011);
    wait_done(1, 200);
    raise(0, 14'h3fff, 14'h0007);
    wait_done(1, 200);
    keep[2] = 1'b0;
    wait_done(1, 200);
    chk_order("t3", 2, 0, 2, 3);
    repeat (3) @(posedge clk);
    #1;

    // Divider never answers.
    served.delete();
    fix_to = 1;
    raise(3, 14'h0800, 14'h0040);
    wait_done(1, 200);
    fix_to = 0;
    chk_order("t4", 3, 0, 0, 1);
    chk("t4_to", to_o, 1);
    chk("t4_q", q_o, 0);
    repeat (3) @(posedge clk);
    #1;

    // Valid still high from the previous op at launch.
    fix_h = 3;
    fix_l = 2;
    raise(1, 14'h1234, 14'h0100);
    wait_done(1, 200);
    chk("t5_to", to_o, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset while waiting on the divider.
    begin
      int s0;
      s0 = nstart;
      fix_h = 0;
      fix_l = 30;
      served.delete();
      raise(2, 14'h0600, 14'h0003);
      raise(1, 14'h0555, 14'h0005);
      for (int i = 0; i < 50 && nstart == s0; i++) @(posedge clk);
      chk("t6_started", nstart - s0, 1);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_zero("t6_rst");
      sb.delete();
      rr_m = 0;
      for (int k = 0; k < N; k++) inserv[k] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("t6_no_done", done, 0);
      end
      fix_l = -1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_done(2, 200);
      chk_order("t6", 1, 2, 0, 2);
      repeat (3) @(posedge clk);
      #1;
    end

    // Randomised traffic.
    fix_to = -1;
    fix_h = -1;
    fix_l = -1;
    p_drop = 20;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (!req[k] && !inserv[k] && !dropq[k] &&
            $urandom_range(0, 15) == 0)
          raise(k, 14'($urandom),
                ($urandom_range(0, 9) == 0) ? 14'h0 : 14'($urandom));
        if ($urandom_range(0, 63) == 0) keep[k] = !keep[k];
      end
    end
    p_drop = 0;
    for (int k = 0; k < N; k++) keep[k] = 1'b0;
    for (int i = 0; i < 3000 && (req != '0 || sb.size() != 0 || busy);
         i++)
      @(posedge clk);
    #1;
    chk("drain_req", req, 0);
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
